ysyx_22050612_lsu: RTL and testbench

Parametrised multi-cycle load/store unit placed between the EXU and data memory. It replaces the EXU's combinational, word-only memory read path. It accepts one access at a time from the EXU over a valid/ready handshake, and drives an aligned, byte-masked request to memory over a valid/ready request and valid response interface. It returns sign- or zero-extended load data for GPR writeback, and flags misaligned accesses and memory timeouts.

---
 rtl/ysyx_22050612_lsu.sv | 230 +++++++++++++++++++++++
 tb/tb_ysyx_22050612_lsu.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050612_lsu.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22050612_lsu
// Description : Multi-cycle load/store unit between EXU and data memory.
//               Accepts one access at a time, issues an aligned byte-masked
//               memory request, returns extended load data for writeback and
//               flags misaligned accesses and memory timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22050612_lsu #(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 256,
    parameter int AW      = 64
) (
    input  logic                clk,
    input  logic                rst,
    // EXU side
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [AW-1:0]       req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    input  logic [4:0]          req_rd,
    // Memory side
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [AW-1:0]       mem_addr,
    output logic                mem_wen,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [XLEN-1:0]     mem_rdata,
    // Writeback side
    output logic                wb_valid,
    output logic                wb_wen,
    output logic [4:0]          wb_rd,
    output logic [XLEN-1:0]     wb_data,
    output logic                err
);

    localparam int c_NB   = XLEN / 8;
    localparam int c_OFFW = $clog2(c_NB);
    localparam int c_CW   = $clog2(TIMEOUT) + 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t               r_state;
    logic                 r_wen;
    logic [1:0]           r_size;
    logic                 r_unsigned;
    logic [4:0]           r_rd;
    logic [c_OFFW-1:0]    r_off;
    logic [c_CW-1:0]      r_cnt;

    logic                 r_mem_req_valid;
    logic [AW-1:0]        r_mem_addr;
    logic [XLEN-1:0]      r_mem_wdata;
    logic [c_NB-1:0]      r_mem_wmask;

    logic                 r_wb_valid;
    logic                 r_wb_wen;
    logic [4:0]           r_wb_rd;
    logic [XLEN-1:0]      r_wb_data;
    logic                 r_err;

    logic [c_OFFW-1:0]    w_off;
    logic [AW-1:0]        w_mem_addr;
    logic [c_NB-1:0]      w_base_mask;
    logic [c_NB-1:0]      w_mask;
    logic [XLEN-1:0]      w_wdata_sh;
    logic                 w_misal;
    logic                 w_bad;
    logic [XLEN-1:0]      w_rshift;
    logic                 w_fill;
    int                   w_nbits;
    logic [XLEN-1:0]      w_load;

    assign w_off      = req_addr[c_OFFW-1:0];
    assign w_mem_addr = {req_addr[AW-1:c_OFFW], {c_OFFW{1'b0}}};
    assign w_mask     = w_base_mask << w_off;
    assign w_wdata_sh = req_wdata << {w_off, 3'b000};
    assign w_rshift   = mem_rdata >> {r_off, 3'b000};

    // Request decode: byte-lane mask for the access size and alignment/legality check
    always_comb begin
        w_base_mask = '0;
        w_misal     = 1'b0;
        case (req_size)
            2'd0: begin
                w_base_mask = c_NB'(1);
                w_misal     = 1'b0;
            end
            2'd1: begin
                w_base_mask = c_NB'(3);
                w_misal     = req_addr[0];
            end
            2'd2: begin
                w_base_mask = c_NB'(15);
                w_misal     = |req_addr[1:0];
            end
            default: begin
                w_base_mask = {c_NB{1'b1}};
                w_misal     = |req_addr[2:0];
            end
        endcase
        // Doubleword accesses do not exist on a 32-bit bus
        w_bad = w_misal || ((XLEN == 32) && (req_size == 2'd3));
    end

    // Load extraction: lane already shifted down, fill bits above the access width
    always_comb begin
        w_nbits = 8 << r_size;
        w_fill  = 1'b0;
        case (r_size)
            2'd0:    w_fill = w_rshift[7];
            2'd1:    w_fill = w_rshift[15];
            2'd2:    w_fill = w_rshift[31];
            default: w_fill = 1'b0;
        endcase
        w_fill = w_fill & ~r_unsigned;
        w_load = '0;
        for (int i = 0; i < XLEN; i++) begin
            w_load[i] = (i < w_nbits) ? w_rshift[i] : w_fill;
        end
    end

    // Access FSM: capture, memory request, response wait with timeout, writeback pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_wen           <= 1'b0;
            r_size          <= 2'd0;
            r_unsigned      <= 1'b0;
            r_rd            <= 5'd0;
            r_off           <= '0;
            r_cnt           <= '0;
            r_mem_req_valid <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wdata     <= '0;
            r_mem_wmask     <= '0;
            r_wb_valid      <= 1'b0;
            r_wb_wen        <= 1'b0;
            r_wb_rd         <= 5'd0;
            r_wb_data       <= '0;
            r_err           <= 1'b0;
        end else begin
            // Completion flags are single-cycle pulses
            r_wb_valid <= 1'b0;
            r_wb_wen   <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_wen       <= req_wen;
                        r_size      <= req_size;
                        r_unsigned  <= req_unsigned;
                        r_rd        <= req_rd;
                        r_off       <= w_off;
                        r_mem_addr  <= w_mem_addr;
                        r_mem_wdata <= req_wen ? w_wdata_sh : '0;
                        r_mem_wmask <= req_wen ? w_mask : '0;
                        if (w_bad) begin
                            // Reject without touching memory
                            r_state    <= ST_DONE;
                            r_wb_valid <= 1'b1;
                            r_err      <= 1'b1;
                            r_wb_rd    <= req_rd;
                            r_wb_data  <= '0;
                        end else begin
                            r_state         <= ST_REQ;
                            r_mem_req_valid <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_cnt           <= '0;
                        r_state         <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_resp_valid) begin
                        r_state    <= ST_DONE;
                        r_wb_valid <= 1'b1;
                        r_wb_wen   <= ~r_wen && (r_rd != 5'd0);
                        r_wb_rd    <= r_rd;
                        r_wb_data  <= r_wen ? '0 : w_load;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_state    <= ST_DONE;
                        r_wb_valid <= 1'b1;
                        r_err      <= 1'b1;
                        r_wb_rd    <= r_rd;
                        r_wb_data  <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready     = (r_state == ST_IDLE);
    assign mem_req_valid = r_mem_req_valid;
    assign mem_addr      = r_mem_addr;
    assign mem_wen       = r_wen;
    assign mem_wdata     = r_mem_wdata;
    assign mem_wmask     = r_mem_wmask;
    assign wb_valid      = r_wb_valid;
    assign wb_wen        = r_wb_wen;
    assign wb_rd         = r_wb_rd;
    assign wb_data       = r_wb_data;
    assign err           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050612_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_22050612_lsu
// Description : Self-checking bench for the load/store unit. A per-cycle
//               expectation model derived from access rules is compared with
//               the DUT every cycle; literal values pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22050612_lsu;

    localparam int c_TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // 64-bit DUT
    logic        req_valid = 1'b0, req_ready, req_wen = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        mem_req_valid, mem_req_ready = 1'b0, mem_wen, mem_resp_valid = 1'b0;
    logic [63:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic [7:0]  mem_wmask;
    logic        wb_valid, wb_wen, err;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;

    // 32-bit DUT
    logic        d2_req_valid = 1'b0, d2_req_ready, d2_req_wen = 1'b0, d2_req_unsigned = 1'b0;
    logic [1:0]  d2_req_size = 2'd0;
    logic [31:0] d2_req_addr = '0, d2_req_wdata = '0;
    logic [4:0]  d2_req_rd = '0;
    logic        d2_mem_req_valid, d2_mem_req_ready = 1'b1, d2_mem_wen, d2_mem_resp_valid = 1'b0;
    logic [31:0] d2_mem_addr, d2_mem_wdata, d2_mem_rdata = '0;
    logic [3:0]  d2_mem_wmask;
    logic        d2_wb_valid, d2_wb_wen, d2_err;
    logic [4:0]  d2_wb_rd;
    logic [31:0] d2_wb_data;

    ysyx_22050612_lsu #(.XLEN(64), .TIMEOUT(c_TO), .AW(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data), .err(err)
    );

    ysyx_22050612_lsu #(.XLEN(32), .TIMEOUT(c_TO), .AW(32)) dut32 (
        .clk(clk), .rst(rst),
        .req_valid(d2_req_valid), .req_ready(d2_req_ready), .req_wen(d2_req_wen),
        .req_size(d2_req_size), .req_unsigned(d2_req_unsigned), .req_addr(d2_req_addr),
        .req_wdata(d2_req_wdata), .req_rd(d2_req_rd),
        .mem_req_valid(d2_mem_req_valid), .mem_req_ready(d2_mem_req_ready),
        .mem_addr(d2_mem_addr), .mem_wen(d2_mem_wen), .mem_wdata(d2_mem_wdata),
        .mem_wmask(d2_mem_wmask), .mem_resp_valid(d2_mem_resp_valid), .mem_rdata(d2_mem_rdata),
        .wb_valid(d2_wb_valid), .wb_wen(d2_wb_wen), .wb_rd(d2_wb_rd), .wb_data(d2_wb_data),
        .err(d2_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (access rules) ----------------
    function automatic logic m_misal(input logic [63:0] addr, input logic [1:0] size);
        int n;
        n = 1 << size;
        return (addr % n) != 0;
    endfunction

    function automatic logic [7:0] m_mask(input logic wen, input logic [1:0] size, input logic [63:0] addr);
        int off, n;
        logic [7:0] m;
        off = int'(addr % 8);
        n = 1 << size;
        m = '0;
        for (int i = 0; i < 8; i++) m[i] = wen && (i >= off) && (i < off + n);
        return m;
    endfunction

    function automatic logic [63:0] m_load(input logic [63:0] rdata, input logic [1:0] size,
                                           input logic uns, input logic [63:0] addr);
        int off, n;
        logic [63:0] v;
        off = int'(addr % 8);
        n = 1 << size;
        v = '0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = rdata[8*(off+k) +: 8];
        if (!uns && n < 8 && v[8*n-1]) begin
            for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
        end
        return v;
    endfunction

    // Expected per-cycle outputs
    logic        chk_en = 1'b0;
    logic        exp_ready = 1'b1, exp_mreq = 1'b0, exp_mwen = 1'b0;
    logic [63:0] exp_maddr = '0, exp_mwdata = '0;
    logic [7:0]  exp_mwmask = '0;
    logic        exp_wbv = 1'b0, exp_wbwen = 1'b0, exp_err = 1'b0;
    logic [4:0]  exp_wbrd = '0;
    logic [63:0] exp_wbdata = '0;

    // Observed values for literal pins
    logic [63:0] last_maddr = '0, last_mwdata = '0, last_wb_data = '0;
    logic [7:0]  last_mwmask = '0;
    logic        last_mwen = 1'b0, last_wb_wen = 1'b0, last_err = 1'b0;
    int          last_wb_cyc = -1, last_hs_cyc = 0, wait_cyc = 0;

    // Compare process: checks DUT against model every cycle, away from the active edge
    always @(negedge clk) begin
        if (mem_req_valid) begin
            last_maddr = mem_addr; last_mwdata = mem_wdata;
            last_mwmask = mem_wmask; last_mwen = mem_wen;
        end
        if (wb_valid) begin
            last_wb_data = wb_data; last_wb_wen = wb_wen; last_err = err; last_wb_cyc = cyc;
        end
        if (chk_en) begin
            chk("req_ready", 64'(req_ready), 64'(exp_ready));
            chk("mem_req_valid", 64'(mem_req_valid), 64'(exp_mreq));
            if (exp_mreq) begin
                chk("mem_addr", mem_addr, exp_maddr);
                chk("mem_wen", 64'(mem_wen), 64'(exp_mwen));
                chk("mem_wmask", 64'(mem_wmask), 64'(exp_mwmask));
                if (exp_mwen) chk("mem_wdata", mem_wdata, exp_mwdata);
            end
            chk("wb_valid", 64'(wb_valid), 64'(exp_wbv));
            if (exp_wbv) begin
                chk("wb_wen", 64'(wb_wen), 64'(exp_wbwen));
                chk("wb_rd", 64'(wb_rd), 64'(exp_wbrd));
                chk("wb_data", wb_data, exp_wbdata);
                chk("err", 64'(err), 64'(exp_err));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One EXU access; respond=0 lets the memory time out
    task automatic do_access(input logic wen, input logic [1:0] size, input logic uns,
                             input logic [63:0] addr, input logic [63:0] wdata, input logic [4:0] rd,
                             input int rdy_dly, input int resp_dly,
                             input logic [63:0] rdata, input logic respond);
        logic bad;
        bad = m_misal(addr, size);
        last_wb_cyc = -1;
        req_valid = 1'b1; req_wen = wen; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_rd = rd;
        tick();
        req_valid = 1'b0;
        last_hs_cyc = cyc - 1;
        exp_ready = 1'b0;
        if (bad) begin
            exp_wbv = 1'b1; exp_err = 1'b1; exp_wbwen = 1'b0; exp_wbdata = '0; exp_wbrd = rd;
        end else begin
            exp_mreq = 1'b1; exp_maddr = addr & ~64'h7; exp_mwen = wen;
            exp_mwdata = wdata << (8 * (addr % 8)); exp_mwmask = m_mask(wen, size, addr);
            mem_req_ready = 1'b0;
            repeat (rdy_dly) tick();
            mem_req_ready = 1'b1;
            tick();
            mem_req_ready = 1'b0;
            exp_mreq = 1'b0;
            wait_cyc = cyc;
            if (respond) begin
                repeat (resp_dly) tick();
                mem_rdata = rdata; mem_resp_valid = 1'b1;
                tick();
                mem_resp_valid = 1'b0;
                exp_wbv = 1'b1; exp_err = 1'b0; exp_wbrd = rd;
                exp_wbwen = !wen && (rd != 5'd0);
                exp_wbdata = wen ? 64'd0 : m_load(rdata, size, uns, addr);
            end else begin
                repeat (c_TO) tick();
                exp_wbv = 1'b1; exp_err = 1'b1; exp_wbwen = 1'b0; exp_wbdata = '0; exp_wbrd = rd;
            end
        end
        tick();
        exp_wbv = 1'b0; exp_err = 1'b0; exp_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_wb_data", wb_data, 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_wmask", 64'(mem_wmask), 64'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("ready_after_rst", 64'(req_ready), 64'd1);
        // Stale response right after reset is ignored
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        tick();

        // LB sign-extended, minimum latency
        do_access(1'b0, 2'd0, 1'b0, 64'h80000003, 64'd0, 5'd5, 0, 0, 64'h1122334488996677, 1'b1);
        chk("lb_data", last_wb_data, 64'hFFFFFFFFFFFFFF88);
        chk("lb_maddr", last_maddr, 64'h80000000);
        chk("lb_wmask", 64'(last_mwmask), 64'h00);
        chk("lb_wb_wen", 64'(last_wb_wen), 64'd1);
        chk("lb_latency", 64'(last_wb_cyc - last_hs_cyc), 64'd3);

        // LWU / LW / LW rd=0
        do_access(1'b0, 2'd2, 1'b1, 64'h80000004, 64'd0, 5'd7, 0, 0, 64'hDEADBEEF00000000, 1'b1);
        chk("lwu_data", last_wb_data, 64'h00000000DEADBEEF);
        do_access(1'b0, 2'd2, 1'b0, 64'h80000004, 64'd0, 5'd7, 0, 1, 64'hDEADBEEF00000000, 1'b1);
        chk("lw_data", last_wb_data, 64'hFFFFFFFFDEADBEEF);
        do_access(1'b0, 2'd2, 1'b0, 64'h80000004, 64'd0, 5'd0, 1, 0, 64'hDEADBEEF00000000, 1'b1);
        chk("lw_rd0_wen", 64'(last_wb_wen), 64'd0);

        // SH with slow memory acceptance
        do_access(1'b1, 2'd1, 1'b0, 64'h80000006, 64'h1234, 5'd9, 5, 2, 64'hFFFFFFFFFFFFFFFF, 1'b1);
        chk("sh_wmask", 64'(last_mwmask), 64'hC0);
        chk("sh_wdata", last_mwdata, 64'h1234000000000000);
        chk("sh_mwen", 64'(last_mwen), 64'd1);
        chk("sh_wb_data", last_wb_data, 64'd0);

        // Misaligned LW: no memory request, error one cycle after acceptance
        do_access(1'b0, 2'd2, 1'b0, 64'h80000002, 64'd0, 5'd3, 0, 0, 64'd0, 1'b1);
        chk("mis_err", 64'(last_err), 64'd1);
        chk("mis_latency", 64'(last_wb_cyc - last_hs_cyc), 64'd1);

        // More patterns: LD, SB, LHU, SD, unsigned LD (ignored flag)
        do_access(1'b0, 2'd3, 1'b0, 64'h80000008, 64'd0, 5'd1, 0, 0, 64'h0123456789ABCDEF, 1'b1);
        do_access(1'b1, 2'd0, 1'b0, 64'h80000001, 64'hAB, 5'd3, 2, 0, 64'd0, 1'b1);
        chk("sb_wmask", 64'(last_mwmask), 64'h02);
        do_access(1'b0, 2'd1, 1'b1, 64'h8000000E, 64'd0, 5'd12, 0, 3, 64'hBEEF000000000000, 1'b1);
        chk("lhu_data", last_wb_data, 64'h000000000000BEEF);
        do_access(1'b1, 2'd3, 1'b0, 64'h80000010, 64'hCAFEF00D12345678, 5'd2, 0, 0, 64'd0, 1'b1);
        do_access(1'b0, 2'd3, 1'b1, 64'h80000018, 64'd0, 5'd31, 0, 0, 64'h8000000000000001, 1'b1);
        do_access(1'b0, 2'd1, 1'b0, 64'h80000002, 64'd0, 5'd4, 0, 0, 64'h00000000F00D0000, 1'b1);

        // Timeout, then a late response that must be ignored
        do_access(1'b0, 2'd1, 1'b0, 64'h80000000, 64'd0, 5'd6, 0, 0, 64'd0, 1'b0);
        chk("to_cycles", 64'(last_wb_cyc - wait_cyc), 64'd16);
        chk("to_err", 64'(last_err), 64'd1);
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        repeat (2) tick();

        // Reset while waiting for a response
        req_valid = 1'b1; req_wen = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 64'h80000020; req_rd = 5'd8;
        tick();
        req_valid = 1'b0; exp_ready = 1'b0;
        exp_mreq = 1'b1; exp_maddr = 64'h80000020; exp_mwen = 1'b0; exp_mwmask = 8'h00;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0; exp_mreq = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0; exp_ready = 1'b1;
        chk("rst_wait_ready", 64'(req_ready), 64'd1);
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        repeat (3) tick();

        // Recovery after reset
        do_access(1'b0, 2'd0, 1'b1, 64'h80000005, 64'd0, 5'd10, 0, 0, 64'h0000F00000000000, 1'b1);
        chk("lbu_data", last_wb_data, 64'h00000000000000F0);

        // 32-bit instance: doubleword is illegal
        d2_req_valid = 1'b1; d2_req_size = 2'd3; d2_req_addr = 32'h80000008; d2_req_rd = 5'd4;
        chk("x32_ready", 64'(d2_req_ready), 64'd1);
        tick();
        d2_req_valid = 1'b0;
        chk("x32_d_wb_valid", 64'(d2_wb_valid), 64'd1);
        chk("x32_d_err", 64'(d2_err), 64'd1);
        chk("x32_d_wb_wen", 64'(d2_wb_wen), 64'd0);
        chk("x32_d_mreq", 64'(d2_mem_req_valid), 64'd0);
        tick();
        chk("x32_d_done", 64'(d2_wb_valid), 64'd0);

        // 32-bit instance: LH at byte offset 2
        d2_req_valid = 1'b1; d2_req_size = 2'd1; d2_req_addr = 32'h80000002; d2_req_rd = 5'd9;
        tick();
        d2_req_valid = 1'b0;
        chk("x32_lh_mreq", 64'(d2_mem_req_valid), 64'd1);
        chk("x32_lh_maddr", 64'(d2_mem_addr), 64'h80000000);
        tick();
        d2_mem_rdata = 32'h80010000; d2_mem_resp_valid = 1'b1;
        tick();
        d2_mem_resp_valid = 1'b0;
        chk("x32_lh_wb_valid", 64'(d2_wb_valid), 64'd1);
        chk("x32_lh_data", 64'(d2_wb_data), 64'hFFFF8001);
        chk("x32_lh_wen", 64'(d2_wb_wen), 64'd1);
        tick();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
